// File: rtl/obstacle_collision_detector.sv
// obstacle_collision_detector
// Watches player/obstacle drawing requests during the scan, accumulates any
// overlap over a frame and issues at most one registered collision pulse per
// frame, aligned to startOfFrame. A frame-count cooldown suppresses repeat
// pulses during one sustained contact.
module obstacle_collision_detector #(
   parameter int OBJECT_WIDTH_X  = 64,
   parameter int OBJECT_HEIGHT_Y = 32,
   parameter int EDGE_MARGIN     = 4,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               playerDR,
   input  logic               obstacleDR,
   input  logic        [10:0] pixelX,
   input  logic        [10:0] pixelY,
   input  logic signed [10:0] obstacleTopLeftX,
   input  logic signed [10:0] obstacleTopLeftY,
   output logic               collision,
   output logic        [3:0]  HitEdgeCode,
   output logic        [7:0]  collisionCount
);

   localparam logic [1:0] ST_ARMED    = 2'd0;
   localparam logic [1:0] ST_PULSE    = 2'd1;
   localparam logic [1:0] ST_COOLDOWN = 2'd2;

   // Wide enough to hold COOLDOWN_FRAMES, and at least one bit when it is 0.
   localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 2);

   localparam logic signed [11:0] MARGIN_S = 12'(EDGE_MARGIN);
   localparam logic signed [11:0] R_LIMIT  = 12'(OBJECT_WIDTH_X - EDGE_MARGIN);
   localparam logic signed [11:0] B_LIMIT  = 12'(OBJECT_HEIGHT_Y - EDGE_MARGIN);

   // Offsets of the current pixel relative to the obstacle corner. One extra
   // bit keeps pixels left/above the obstacle negative, so they classify as
   // Left/Top through the signed compare.
   logic signed [11:0] off_x;
   logic signed [11:0] off_y;
   logic        [3:0]  edge_now;

   assign off_x = $signed({1'b0, pixelX}) - $signed({obstacleTopLeftX[10], obstacleTopLeftX});
   assign off_y = $signed({1'b0, pixelY}) - $signed({obstacleTopLeftY[10], obstacleTopLeftY});

   // {Left, Top, Right, Bottom}
   assign edge_now = {(off_x < MARGIN_S), (off_y < MARGIN_S),
                      (off_x >= R_LIMIT), (off_y >= B_LIMIT)};

   logic             ov_q,        ov_d;
   logic [3:0]       edge_q,      edge_d;
   logic             hit_q,       hit_d;
   logic [3:0]       edge_acc_q,  edge_acc_d;
   logic [1:0]       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             collision_q, collision_d;
   logic [3:0]       hec_q,       hec_d;
   logic [7:0]       count_q,     count_d;

   // Overlap stage: register the coincidence and its edge classification together.
   always_comb begin
      ov_d   = playerDR & obstacleDR;
      edge_d = edge_now;
   end

   // Frame accumulators: restart at each frame start, keeping the staged pixel
   // that lands on that same cycle as the first pixel of the new frame.
   always_comb begin
      hit_d      = hit_q;
      edge_acc_d = edge_acc_q;
      if (startOfFrame) begin
         hit_d      = ov_q;
         edge_acc_d = ov_q ? edge_q : 4'b0000;
      end else if (ov_q) begin
         hit_d      = 1'b1;
         edge_acc_d = edge_acc_q | edge_q;
      end
   end

   // Pulse/cooldown controller. The pulse and count update are issued on the
   // transition into PULSE so that collision, HitEdgeCode and collisionCount
   // all change together on the cycle after startOfFrame.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      collision_d = 1'b0;
      hec_d       = hec_q;
      count_d     = count_q;
      case (state_q)
         ST_ARMED: begin
            if (startOfFrame && hit_q) begin
               hec_d       = edge_acc_q;
               collision_d = 1'b1;
               if (count_q != 8'hFF) begin
                  count_d = count_q + 8'd1;
               end
               state_d     = ST_PULSE;
            end
         end
         ST_PULSE: begin
            cnt_d = CNT_W'(COOLDOWN_FRAMES);
            if (COOLDOWN_FRAMES == 0) begin
               state_d = ST_ARMED;
            end else begin
               state_d = ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            // The frame start that brings the count to zero re-arms; the
            // frame it opens is eligible, but it cannot pulse itself.
            if (startOfFrame) begin
               if (cnt_q <= CNT_W'(1)) begin
                  cnt_d   = '0;
                  state_d = ST_ARMED;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_ARMED;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         ov_q        <= 1'b0;
         edge_q      <= 4'b0000;
         hit_q       <= 1'b0;
         edge_acc_q  <= 4'b0000;
         state_q     <= ST_ARMED;
         cnt_q       <= '0;
         collision_q <= 1'b0;
         hec_q       <= 4'b0000;
         count_q     <= 8'd0;
      end else begin
         ov_q        <= ov_d;
         edge_q      <= edge_d;
         hit_q       <= hit_d;
         edge_acc_q  <= edge_acc_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         collision_q <= collision_d;
         hec_q       <= hec_d;
         count_q     <= count_d;
      end
   end

   assign collision      = collision_q;
   assign HitEdgeCode    = hec_q;
   assign collisionCount = count_q;

endmodule

// File: tb/tb_obstacle_collision_detector.sv
// Directed bench for obstacle_collision_detector: one instance with the
// default 8-frame cooldown and one with no cooldown share the same stimulus.
module tb_obstacle_collision_detector;

   logic               clk = 1'b0;
   logic               resetN;
   logic               startOfFrame;
   logic               playerDR;
   logic               obstacleDR;
   logic        [10:0] pixelX;
   logic        [10:0] pixelY;
   logic signed [10:0] obstacleTopLeftX;
   logic signed [10:0] obstacleTopLeftY;

   logic       col_a, col_b;
   logic [3:0] hec_a, hec_b;
   logic [7:0] cnt_a, cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   int pulse_cnt_b = 0;
   int double_hits = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;

   obstacle_collision_detector #(
      .OBJECT_WIDTH_X(64), .OBJECT_HEIGHT_Y(32), .EDGE_MARGIN(4), .COOLDOWN_FRAMES(8)
   ) dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .playerDR(playerDR), .obstacleDR(obstacleDR),
      .pixelX(pixelX), .pixelY(pixelY),
      .obstacleTopLeftX(obstacleTopLeftX), .obstacleTopLeftY(obstacleTopLeftY),
      .collision(col_a), .HitEdgeCode(hec_a), .collisionCount(cnt_a)
   );

   obstacle_collision_detector #(
      .OBJECT_WIDTH_X(64), .OBJECT_HEIGHT_Y(32), .EDGE_MARGIN(4), .COOLDOWN_FRAMES(0)
   ) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .playerDR(playerDR), .obstacleDR(obstacleDR),
      .pixelX(pixelX), .pixelY(pixelY),
      .obstacleTopLeftX(obstacleTopLeftX), .obstacleTopLeftY(obstacleTopLeftY),
      .collision(col_b), .HitEdgeCode(hec_b), .collisionCount(cnt_b)
   );

   always #5 clk = ~clk;

   // Pulse monitor: counts pulses of the no-cooldown instance and flags any
   // collision held high for two consecutive cycles on either instance.
   always @(negedge clk) begin
      if (col_b) pulse_cnt_b++;
      if ((col_a && prev_a) || (col_b && prev_b)) double_hits++;
      prev_a = col_a;
      prev_b = col_b;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pixel(input int x, input int y, input logic pdr, input logic odr);
      pixelX     = 11'(x);
      pixelY     = 11'(y);
      playerDR   = pdr;
      obstacleDR = odr;
      tick();
      playerDR   = 1'b0;
      obstacleDR = 1'b0;
   endtask

   // Drive startOfFrame, then check instance A on the pulse cycle and the one after.
   task automatic frame_check(input string tag, input logic exp_pulse,
                              input logic [3:0] exp_hec, input int exp_cnt);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      $display("frame %s: collision=%0b edge=%b count=%0d", tag, col_a, hec_a, cnt_a);
      check_val({tag, " collision"}, 32'(col_a), 32'(exp_pulse));
      check_val({tag, " edge"}, 32'(hec_a), 32'(exp_hec));
      check_val({tag, " count"}, 32'(cnt_a), 32'(exp_cnt));
      tick();
      check_val({tag, " collision next"}, 32'(col_a), 32'd0);
   endtask

   // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
   task automatic do_reset(input string tag);
      resetN = 1'b0;
      #2;
      check_val({tag, " rst collision"}, 32'(col_a), 32'd0);
      check_val({tag, " rst edge"}, 32'(hec_a), 32'd0);
      check_val({tag, " rst count"}, 32'(cnt_a), 32'd0);
      check_val({tag, " rst count b"}, 32'(cnt_b), 32'd0);
      tick();
      tick();
      resetN = 1'b1;
      tick();
   endtask

   initial begin
      int exp_cnt;
      int base_b;
      logic exp_p;

      resetN           = 1'b0;
      startOfFrame     = 1'b0;
      playerDR         = 1'b0;
      obstacleDR       = 1'b0;
      pixelX           = '0;
      pixelY           = '0;
      obstacleTopLeftX = 11'sd100;
      obstacleTopLeftY = 11'sd300;
      repeat (3) tick();
      do_reset("init");

      // 1: single left-edge hit; a player-only pixel on the far corner must not count.
      frame_check("t1 f0", 1'b0, 4'b0000, 0);
      pixel(163, 331, 1'b1, 1'b0);
      pixel(101, 310, 1'b1, 1'b1);
      tick();
      frame_check("t1 f1", 1'b1, 4'b1000, 1);
      frame_check("t1 f2", 1'b0, 4'b1000, 1);

      // 2: two corners in one frame merge into all four edges, one pulse.
      do_reset("t2");
      frame_check("t2 f0", 1'b0, 4'b0000, 0);
      pixel(101, 300, 1'b1, 1'b1);
      pixel(163, 331, 1'b1, 1'b1);
      tick();
      frame_check("t2 f1", 1'b1, 4'b1111, 1);
      pixel(101, 300, 1'b1, 1'b1);
      tick();
      frame_check("t2 f2", 1'b0, 4'b1111, 1);

      // 3: sustained contact; pulses at frame starts 1, 10 and 19 only.
      do_reset("t3");
      frame_check("t3 f0", 1'b0, 4'b0000, 0);
      exp_cnt = 0;
      for (int f = 1; f <= 20; f++) begin
         pixel(101, 331, 1'b1, 1'b1);
         tick();
         exp_p = (f == 1) || (f == 10) || (f == 19);
         if (exp_p) exp_cnt++;
         frame_check($sformatf("t3 f%0d", f), exp_p, 4'b1001, exp_cnt);
      end
      check_val("t3 final count", 32'(cnt_a), 32'd3);

      // 4: overlap on the last cycle before startOfFrame belongs to the new frame.
      do_reset("t4");
      frame_check("t4 f0", 1'b0, 4'b0000, 0);
      tick();
      pixel(101, 310, 1'b1, 1'b1);
      frame_check("t4 f1", 1'b0, 4'b0000, 0);
      frame_check("t4 f2", 1'b1, 4'b1000, 1);

      // 5: reset three frames into cooldown discards the cooldown and the interrupted frame.
      do_reset("t5a");
      frame_check("t5 f0", 1'b0, 4'b0000, 0);
      pixel(101, 310, 1'b1, 1'b1);
      tick();
      frame_check("t5 f1", 1'b1, 4'b1000, 1);
      for (int f = 2; f <= 4; f++) frame_check($sformatf("t5 f%0d", f), 1'b0, 4'b1000, 1);
      pixel(101, 310, 1'b1, 1'b1);
      tick();
      do_reset("t5b");
      frame_check("t5 f5", 1'b0, 4'b0000, 0);
      pixel(163, 331, 1'b1, 1'b1);
      tick();
      frame_check("t5 f6", 1'b1, 4'b0011, 1);

      // 6: no-cooldown instance pulses every frame and its count saturates.
      do_reset("t6");
      base_b = pulse_cnt_b;
      for (int f = 0; f < 300; f++) begin
         pixel(101, 310, 1'b1, 1'b1);
         tick();
         startOfFrame = 1'b1;
         tick();
         startOfFrame = 1'b0;
      end
      repeat (3) tick();
      $display("t6: pulses_b=%0d count_b=%0d count_a=%0d", pulse_cnt_b - base_b, cnt_b, cnt_a);
      check_val("t6 pulses b", 32'(pulse_cnt_b - base_b), 32'd300);
      check_val("t6 count b", 32'(cnt_b), 32'd255);
      check_val("t6 edge b", 32'(hec_b), 32'b1000);
      check_val("t6 count a", 32'(cnt_a), 32'd34);

      check_val("single-cycle pulses", 32'(double_hits), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/obstacle_collision_detector.md
# obstacle_collision_detector

Per-frame collision detector that produces the `collision` pulse and `HitEdgeCode` consumed by the moving-obstacle motion controller. It watches the player and obstacle drawing requests pixel by pixel during the VGA scan. Overlaps are accumulated over one frame, and at most one registered collision pulse is issued per frame, aligned to `startOfFrame`. A frame-count cooldown stops the controller from adding speed on every frame of one sustained contact.

## Interface

Parameters:
- `OBJECT_WIDTH_X`, default 64: obstacle width in pixels.
- `OBJECT_HEIGHT_Y`, default 32: obstacle height in pixels.
- `EDGE_MARGIN`, default 4: depth in pixels of each edge band used for `HitEdgeCode`.
- `COOLDOWN_FRAMES`, default 8: number of frames during which overlaps are ignored after a pulse.

Ports:
- `clk`, in, 1: pixel clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `startOfFrame`, in, 1: one-clock pulse at the start of every frame (30 Hz).
- `playerDR`, in, 1: player drawing request for the current pixel.
- `obstacleDR`, in, 1: obstacle drawing request for the current pixel.
- `pixelX`, in, 11: current pixel X (unsigned).
- `pixelY`, in, 11: current pixel Y (unsigned).
- `obstacleTopLeftX`, in, signed 11: obstacle top-left X.
- `obstacleTopLeftY`, in, signed 11: obstacle top-left Y.
- `collision`, out, 1: one-clock collision pulse.
- `HitEdgeCode`, out, 4: edge bits {Left, Top, Right, Bottom} = bits [3:0].
- `collisionCount`, out, 8: count of issued pulses; saturates at 255.

## Operation

**Overlap**
- `overlap = playerDR & obstacleDR`, registered once (stage `ov_d`).
- The offsets and edge bits are registered in the same stage.

**Offsets and edge bits**
- Offsets are 12-bit signed: `offX = pixelX - obstacleTopLeftX`, `offY = pixelY - obstacleTopLeftY`.
- L = `offX < EDGE_MARGIN`.
- R = `offX >= OBJECT_WIDTH_X - EDGE_MARGIN`.
- T = `offY < EDGE_MARGIN`.
- B = `offY >= OBJECT_HEIGHT_Y - EDGE_MARGIN`.
- A negative offset counts as L or T respectively.

**Frame accumulators**
- `hitFlag` (1 bit) and `edgeAcc` (4 bits) are OR-accumulated on every cycle where `ov_d` = 1.
- On `startOfFrame`, both accumulators are cleared.
- If `ov_d` = 1 in that same cycle, the accumulators load that pixel's values, so the pixel belongs to the new frame.

**State machine** (3 states; reset state ARMED)
- ARMED: on `startOfFrame` with `hitFlag` = 1 (the value before clearing):
  - latch `HitEdgeCode` ← `edgeAcc`,
  - go to PULSE.
- ARMED: on `startOfFrame` with `hitFlag` = 0, stay in ARMED and leave `HitEdgeCode` unchanged.
- PULSE (exactly one cycle):
  - `collision` = 1,
  - `collisionCount` += 1, saturating at 255,
  - load the cooldown counter with `COOLDOWN_FRAMES`,
  - go to COOLDOWN.
- COOLDOWN: decrement the counter on each `startOfFrame`; the accumulators keep running but are discarded.
  - When the counter reaches 0, go to ARMED on that same `startOfFrame`.
  - Overlap in the frame that starts at that `startOfFrame` is eligible.
- `COOLDOWN_FRAMES` = 0: PULSE goes directly to ARMED.

**Output hold rules**
- `HitEdgeCode` holds its latched value until the next pulse. It is never cleared except by reset.
- `collision` is registered and never asserted for more than one cycle.
- There is at most one pulse per frame.

**Reset**
- Reset at any time, including mid-frame, mid-PULSE or mid-cooldown, forces the state to ARMED.
- It also sets `collision` = 0, `HitEdgeCode` = 0, `collisionCount` = 0, accumulators = 0 and cooldown counter = 0.
- No pulse is generated for a frame that was interrupted by reset.

## Timing

**Pulse latency**
- `startOfFrame` at cycle N, with an overlap seen in the previous frame: state is PULSE at N+1 and `collision` = 1 at N+1 only.
- `HitEdgeCode` is valid from N+1 and stays stable while `collision` is high.

**Pipeline lag**
- An overlap pixel at cycle k is visible in `hitFlag` at k+2: one cycle for the `ov_d` stage and one for the accumulator.
- An overlap in the final cycle before `startOfFrame` (k = N−1) reaches `ov_d` at N and is therefore counted in the new frame.

**Cooldown timing**
- After a pulse at N+1, the next possible pulse comes `COOLDOWN_FRAMES`+1 frame starts later.
- The frame-start that returns the block to ARMED cannot itself produce a pulse.

## Test plan

1. **Single left-edge hit.**
   - Stimulus: obstacle at (100,300); one overlap pixel at (101,310); then `startOfFrame`.
   - Required: `collision` = 1 for exactly one cycle, 1 cycle after `startOfFrame`; `HitEdgeCode` = 4'b1000; `collisionCount` = 1.
2. **Multi-edge hit in one frame.**
   - Stimulus: overlaps at (101,300) and (163,331) in the same frame.
   - Required: `HitEdgeCode` = 4'b1111; one pulse only.
3. **Sustained contact with `COOLDOWN_FRAMES` = 8.**
   - Stimulus: an overlap in every frame for 20 frames.
   - Required: pulses at frame starts 1, 10 and 19; `collisionCount` = 3.
4. **Frame boundary.**
   - Stimulus: an overlap pixel coincident with `startOfFrame`, with no overlap in the prior frame.
   - Required: no pulse at this `startOfFrame`; a pulse at the following one.
5. **Reset mid-cooldown.**
   - Stimulus: assert `resetN` = 0 asynchronously 3 frames into cooldown.
   - Required: outputs 0 immediately; the next frame's overlap yields a pulse with no cooldown wait.
6. **Counter saturation.**
   - Stimulus: `COOLDOWN_FRAMES` = 0; overlap in 300 consecutive frames.
   - Required: 300 pulses; `collisionCount` = 255.
